// File: rtl/bcd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// bcd_decoder_pkg
// Shared definitions for the sequential BCD-to-binary converter:
//   - state_t        : converter FSM states (IDLE / SHIFT / DONE)
//   - BCD_DIGIT_W    : bits per BCD digit
//   - SEG_W          : bits per seven-segment pattern
//   - SEG_0..SEG_9   : active-low DE1-SoC HEX patterns (bit0 = a ... bit6 = g),
//                      the same table the binary-to-seven-segment encoder uses
//   - min_bin_width  : smallest binary width that holds 10**digits - 1
// ----------------------------------------------------------------------------
package bcd_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int SEG_W       = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    // Alternate glyphs some displays use: 7 with segment f lit, 9 with tail d off.
    localparam logic [SEG_W-1:0] SEG_7_ALT = 7'b1011000;
    localparam logic [SEG_W-1:0] SEG_9_ALT = 7'b0011000;

    // ceil(log2(10**digits)); used to reject an undersized output width.
    function automatic int min_bin_width(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd_decoder_seg7_to_digit.sv
// ----------------------------------------------------------------------------
// seg7_to_digit
// Combinational map of one active-low seven-segment pattern to a BCD digit.
// Ports:
//   seg     in  [6:0] pattern, bit0 = segment a ... bit6 = segment g
//   digit   out [3:0] decoded digit (0 when the pattern is not recognised)
//   invalid out       pattern is not one of the accepted digit glyphs
// ----------------------------------------------------------------------------
module seg7_to_digit
    import bcd_decoder_pkg::*;
(
    input  logic [SEG_W-1:0]       seg,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   invalid
);

    always_comb begin
        digit   = 4'd0;
        invalid = 1'b0;
        case (seg)
            SEG_0:                digit = 4'd0;
            SEG_1:                digit = 4'd1;
            SEG_2:                digit = 4'd2;
            SEG_3:                digit = 4'd3;
            SEG_4:                digit = 4'd4;
            SEG_5:                digit = 4'd5;
            SEG_6:                digit = 4'd6;
            SEG_7, SEG_7_ALT:     digit = 4'd7;
            SEG_8:                digit = 4'd8;
            SEG_9, SEG_9_ALT:     digit = 4'd9;
            default:              invalid = 1'b1;  // includes blank 1111111
        endcase
    end

endmodule

// File: rtl/bcd_decoder.sv
// ----------------------------------------------------------------------------
// bcd_decoder
// Sequential BCD-to-binary converter using reverse double-dabble: the
// {digits, accumulator} register is shifted right one bit per clock and every
// digit that reads >= 8 afterwards is corrected by subtracting 3.
//
// Build option: define BCD_DECODER_SEG_IN_EN to replace i_bcd with i_seg
// (active-low seven-segment patterns, 7 bits per digit). Unrecognised patterns
// are reported through o_err like an out-of-range BCD digit.
//
// Parameters:
//   p_digits    number of BCD digits (default 3)
//   p_bin_width output width, must be >= ceil(log2(10**p_digits)) (default 10)
// Ports:
//   i_clock_50mhz in   system clock
//   i_reset_n     in   asynchronous active-low reset
//   i_start       in   request strobe, only sampled in IDLE
//   i_bcd         in   packed BCD, digit 0 (ones) in [3:0]   (default build)
//   i_seg         in   packed segment patterns, digit 0 in [6:0] (option)
//   o_busy        out  high while a conversion is in flight (SHIFT/DONE)
//   o_valid       out  one-cycle result pulse
//   o_err         out  an input digit was invalid; qualified by o_valid
//   o_bin         out  binary result, held until the next o_valid
// ----------------------------------------------------------------------------
module bcd_decoder
    import bcd_decoder_pkg::*;
#(
    parameter int p_digits    = 3,
    parameter int p_bin_width = 10
) (
    input  logic                           i_clock_50mhz,
    input  logic                           i_reset_n,
    input  logic                           i_start,
`ifdef BCD_DECODER_SEG_IN_EN
    input  logic [SEG_W*p_digits-1:0]      i_seg,
`else
    input  logic [BCD_DIGIT_W*p_digits-1:0] i_bcd,
`endif
    output logic                           o_busy,
    output logic                           o_valid,
    output logic                           o_err,
    output logic [p_bin_width-1:0]         o_bin
);

    localparam int DW    = BCD_DIGIT_W * p_digits;
    localparam int CNT_W = $clog2(DW);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW - 1);

    if (p_bin_width < min_bin_width(p_digits)) begin : g_width_check
        $fatal(1, "bcd_decoder: p_bin_width=%0d too small for %0d digits",
               p_bin_width, p_digits);
    end

    state_t           state_reg;
    logic [DW-1:0]    digits_reg;
    logic [DW-1:0]    acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // ---------------- input digits and validity ----------------
    logic [DW-1:0]       in_digits;
    logic [p_digits-1:0] in_bad;

    genvar gi;
    generate
        for (gi = 0; gi < p_digits; gi++) begin : g_in
`ifdef BCD_DECODER_SEG_IN_EN
            seg7_to_digit u_seg (
                .seg     (i_seg[gi*SEG_W +: SEG_W]),
                .digit   (in_digits[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .invalid (in_bad[gi])
            );
`else
            assign in_digits[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
                i_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
            assign in_bad[gi] = (i_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9);
`endif
        end
    endgenerate

    // ---------------- one reverse double-dabble step ----------------
    logic [2*DW-1:0] shifted;
    logic [DW-1:0]   digits_next;
    logic [DW-1:0]   acc_next;

    assign shifted  = {digits_reg, acc_reg} >> 1;
    assign acc_next = shifted[DW-1:0];

    generate
        for (gi = 0; gi < p_digits; gi++) begin : g_corr
            // A digit >= 8 after the shift means a "ten" moved into its MSB
            // position as weight 8; subtracting 3 restores weight 5.
            localparam int LSB = DW + gi*BCD_DIGIT_W;
            assign digits_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
                shifted[LSB + BCD_DIGIT_W - 1]
                    ? shifted[LSB +: BCD_DIGIT_W] - 4'd3
                    : shifted[LSB +: BCD_DIGIT_W];
        end
    endgenerate

    // Accumulator holds the full result; width adapts to p_bin_width
    // (the parameter check makes narrowing lossless).
    logic [p_bin_width-1:0] acc_result;
    assign acc_result = p_bin_width'(acc_reg);

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge i_clock_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg  <= IDLE;
            digits_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_bin      <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        digits_reg <= in_digits;
                        acc_reg    <= '0;
                        cnt_reg    <= CNT_LOAD;
                        err_reg    <= |in_bad;
                        o_busy     <= 1'b1;
                        state_reg  <= (|in_bad) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    digits_reg <= digits_next;
                    acc_reg    <= acc_next;
                    cnt_reg    <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    o_valid   <= 1'b1;
                    o_err     <= err_reg;
                    o_bin     <= err_reg ? '0 : acc_result;
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_decoder.md
Name: bcd_decoder

Overview:
- Sequential BCD-to-binary converter; the inverse of the board's binary-to-BCD/seven-segment encoder path.
- Accepts p_digits packed BCD digits on a start strobe.
- Converts iteratively by reverse double-dabble (shift right, subtract-3 correction), one bit per clock.
- Returns the binary value with a one-cycle valid pulse; used in the DE1-SoC top to check the encoder loop and to read decimal entry back into binary.

Parameters:
- p_digits, 3: number of BCD digits converted.
- p_bin_width, 10: output width; must be >= ceil(log2(10^p_digits)), checked at elaboration (fatal error otherwise).

Ports:
- i_clock_50mhz  input  1  system clock, 50 MHz.
- i_reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  request strobe; sampled only in IDLE.
- i_bcd  input  4*p_digits  packed BCD, digit 0 (ones) in bits [3:0].
- o_busy  output  1  high from the cycle after an accepted start until the return to IDLE.
- o_valid  output  1  one-cycle pulse, result/err valid.
- o_err  output  1  qualified by o_valid; an input digit was > 9.
- o_bin  output  p_bin_width  binary result; held until the next o_valid.

Behaviour:
- Interface: one clock, i_clock_50mhz; reset is asynchronous, active-low, on i_reset_n.
- Reset values: o_busy=0, o_valid=0, o_err=0, o_bin=0, state=IDLE, internal registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On i_start=1: latch i_bcd into the digit shift register, clear the 4*p_digits-bit binary accumulator, load bit counter with 4*p_digits-1.
  - If any latched digit > 9: go to DONE with err flag set, no SHIFT.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Shift {digits, accumulator} right by one.
  - Then, in each digit position of the shifted value, subtract 3 where the digit is >= 8.
  - Decrement the counter; after 4*p_digits shifts (counter was 0), go to DONE.
- DONE (one cycle):
  - o_valid=1.
  - o_bin = accumulator[p_bin_width-1:0], or 0 on error.
  - o_err = err flag.
  - Next state IDLE.
- Latency, start sampled at edge 0:
  - Normal: o_valid high in the cycle after edge 4*p_digits+1 (13 for default).
  - Error: o_valid high after edge 1.
- o_busy is high in SHIFT and DONE, low in IDLE.
- i_start while not IDLE: ignored, not queued.
- i_bcd changes after acceptance: no effect on the conversion in flight.
- Back-to-back: i_start held high is accepted again in the first IDLE cycle after DONE; peak throughput is one result per 4*p_digits+2 cycles.
- Reset mid-conversion: immediate abort, all outputs to reset values, no o_valid.
- Arithmetic: the subtract-3 correction never underflows (applied only to digits >= 8). The result always fits the accumulator; truncation to p_bin_width is lossless given the parameter check.

Optional Feature:
- Macro: BCD_DECODER_SEG_IN_EN.
- Defined:
  - i_bcd is replaced by i_seg (input, 7*p_digits): active-low DE1-SoC HEX patterns, bit0=segment a ... bit6=g, digit 0 in [6:0].
  - Each 7-bit field is mapped to a digit by the combinational sub-module; it is sampled on start exactly as i_bcd was.
  - Required codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (also accept 7=1011000 and 9=0011000).
  - Any other pattern, including 1111111 (blank), maps to an error and sets o_err as for digit > 9.
- Undefined: i_bcd port only; no segment logic is present.

Decomposition:
- Package bcd_decoder_pkg holds:
  - state enum (IDLE/SHIFT/DONE);
  - BCD_DIGIT_W=4, SEG_W=7;
  - the ten seven-segment code constants, shared with the encoder's segment table.
- Sub-module seg7_to_digit: combinational 7-bit pattern to {invalid, 4-bit digit}, instantiated p_digits times under BCD_DECODER_SEG_IN_EN.

Test Plan:
- Reset, then i_bcd=12'h999, start -> o_valid after 13 edges, o_bin=999, o_err=0, o_busy high exactly 13 cycles.
- i_bcd=12'h000, then 12'h001, then 12'h512 -> o_bin=0, 1, 512 respectively; o_bin held between pulses.
- i_bcd=12'h9A5, start -> o_valid after 1 edge, o_err=1, o_bin=0; next start with 12'h123 -> o_bin=123, o_err=0.
- Start 12'h456, pulse i_start again at cycles 3 and 8, and change i_bcd to 12'h777 at cycle 2 -> single o_valid, o_bin=456.
- Start 12'h321, assert i_reset_n=0 at cycle 6 -> outputs zero immediately, no o_valid; after release, start 12'h321 -> o_bin=321.
- With BCD_DECODER_SEG_IN_EN: i_seg={0010000,0000000,1111001} -> o_bin=981; middle digit 1111111 -> o_err=1.
